// File: rtl/foo_pkg.sv
// -----------------------------------------------------------------------------
// foo_pkg
// Shared defaults for the foo AND unit and its saturating event counter.
// No ports; imported by foo_sat_counter and foo_and_unit.
// -----------------------------------------------------------------------------
package foo_pkg;

    // Default operand / result width of the AND gate.
    localparam int unsigned FOO_WIDTH_DEF = 1;

    // Default width of the all-ones event counter.
    localparam int unsigned FOO_CNT_W_DEF = 16;

endpackage

// File: rtl/foo_sat_counter.sv
// -----------------------------------------------------------------------------
// foo_sat_counter
// Up-counter that sticks at its maximum value, with a synchronous clear that
// takes priority over a same-cycle increment.
//
// Ports
//   clk    in   1      system clock, rising edge
//   rst_n  in   1      asynchronous active-low reset, clears cnt
//   inc    in   1      increment request for this cycle
//   clr    in   1      synchronous clear, wins over inc
//   cnt    out  CNT_W  current count
//   sat    out  1      high while cnt is at its maximum value
// -----------------------------------------------------------------------------
module foo_sat_counter
    import foo_pkg::*;
#(
    parameter int unsigned CNT_W = FOO_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt_d = cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_d;
        end
    end

    // Derived from cnt so it clears together with cnt on reset and on clr.
    assign sat = (cnt == CNT_MAX);

endmodule

// File: rtl/foo_and_unit.sv
// -----------------------------------------------------------------------------
// foo_and_unit
// Bitwise 2-input AND gate with a registered shadow copy and an activity
// monitor that counts rising edges of the registered "all bits high" flag.
//
// Ports
//   clk     in   1      system clock, rising edge
//   rst_n   in   1      asynchronous active-low reset (does not affect Y)
//   A       in   WIDTH  operand A
//   B       in   WIDTH  operand B
//   Y       out  WIDTH  A & B, combinational, zero latency
//   Y_q     out  WIDTH  A & B, registered, one cycle latency
//   all_q   out  1      registered &(A & B)
//   ev_cnt  out  CNT_W  saturating count of all_q rising edges
//   ev_sat  out  1      high while ev_cnt is at its maximum
//   clr     in   1      synchronous clear of ev_cnt / ev_sat
// -----------------------------------------------------------------------------
module foo_and_unit
    import foo_pkg::*;
#(
    parameter int unsigned WIDTH = FOO_WIDTH_DEF,
    parameter int unsigned CNT_W = FOO_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Y_q,
    output logic             all_q,
    output logic [CNT_W-1:0] ev_cnt,
    output logic             ev_sat,
    input  logic             clr
);

    logic [WIDTH-1:0] y_and;
    logic             all_d;
    logic             ev_rise;

    assign y_and = A & B;
    assign Y     = y_and;

    // all_d is one cycle behind all_q, so the rise is seen one cycle after
    // all_q goes high. clr deliberately leaves this history untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y_q   <= '0;
            all_q <= 1'b0;
            all_d <= 1'b0;
        end else begin
            Y_q   <= y_and;
            all_q <= &y_and;
            all_d <= all_q;
        end
    end

    assign ev_rise = all_q & ~all_d;

    foo_sat_counter #(
        .CNT_W (CNT_W)
    ) u_ev_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ev_rise),
        .clr   (clr),
        .cnt   (ev_cnt),
        .sat   (ev_sat)
    );

endmodule

// File: tb/tb_foo_and_unit.sv
// -----------------------------------------------------------------------------
// tb_foo_and_unit
// Directed bench for foo_and_unit. Three instances: the default configuration,
// a 2-bit counter copy for saturation, and a 4-bit wide copy.
// -----------------------------------------------------------------------------
module tb_foo_and_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Default instance: WIDTH 1, CNT_W 16
    logic        a1, b1, clr1, y1, yq1, allq1, sat1;
    logic [15:0] cnt1;

    // Saturation instance: WIDTH 1, CNT_W 2
    logic        a2, b2, clr2, y2, yq2, allq2, sat2;
    logic [1:0]  cnt2;

    // Wide instance: WIDTH 4, CNT_W 16
    logic [3:0]  a4, b4, y4, yq4;
    logic        clr4, allq4, sat4;
    logic [15:0] cnt4;

    foo_and_unit #(.WIDTH(1), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Y(y1), .Y_q(yq1),
        .all_q(allq1), .ev_cnt(cnt1), .ev_sat(sat1), .clr(clr1)
    );

    foo_and_unit #(.WIDTH(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .A(a2), .B(b2), .Y(y2), .Y_q(yq2),
        .all_q(allq2), .ev_cnt(cnt2), .ev_sat(sat2), .clr(clr2)
    );

    foo_and_unit #(.WIDTH(4), .CNT_W(16)) u_w4 (
        .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .Y(y4), .Y_q(yq4),
        .all_q(allq4), .ev_cnt(cnt4), .ev_sat(sat4), .clr(clr4)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic y;
        logic all;
    } exp_t;

    exp_t sb[$];

    // Reference state for the default instance's activity monitor.
    logic        m_all_q;
    logic        m_all_d;
    logic [15:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs to the default instance and queue the registered result.
    task automatic drive(input logic a, input logic b, input logic c);
        exp_t e;
        a1   = a;
        b1   = b;
        clr1 = c;
        e.y   = a & b;
        e.all = a & b;
        sb.push_back(e);
    endtask

    // One clock: advance the reference, then compare after the edge.
    task automatic tick(input string tag);
        exp_t e;
        logic ev;
        ev = m_all_q & ~m_all_d;
        if (clr1) m_cnt = '0;
        else if (ev && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
        m_all_d = m_all_q;
        m_all_q = a1 & b1;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s_sb: observed empty queue expected one entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_yq"}, 32'(yq1), 32'(e.y));
            check({tag, "_all"}, 32'(allq1), 32'(e.all));
        end
        check({tag, "_cnt"}, 32'(cnt1), 32'(m_cnt));
        check({tag, "_sat"}, 32'(sat1), 32'(m_cnt == 16'hFFFF));
    endtask

    initial begin
        logic [3:0] tt;
        tt = 4'b1000;

        rst_n = 1'b0;
        a1 = 1'b0; b1 = 1'b0; clr1 = 1'b0;
        a2 = 1'b0; b2 = 1'b0; clr2 = 1'b0;
        a4 = 4'h0; b4 = 4'h0; clr4 = 1'b0;
        m_all_q = 1'b0; m_all_d = 1'b0; m_cnt = '0;

        // Reset state
        @(posedge clk);
        #1;
        check("rst_yq",  32'(yq1),   32'd0);
        check("rst_all", 32'(allq1), 32'd0);
        check("rst_cnt", 32'(cnt1),  32'd0);
        check("rst_sat", 32'(sat1),  32'd0);
        a1 = 1'b1; b1 = 1'b1;
        #1;
        check("rst_y_live", 32'(y1), 32'd1);
        a1 = 1'b0; b1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Truth table
        for (int v = 0; v < 4; v++) begin
            logic [1:0] ab;
            ab = 2'(v);
            drive(ab[1], ab[0], 1'b0);
            #1;
            check("tt_y", 32'(y1), 32'(tt[v]));
            tick("tt");
        end
        drive(1'b0, 1'b0, 1'b0);
        tick("tt_ev");
        check("tt_event_cnt", 32'(cnt1), 32'd1);
        drive(1'b0, 1'b0, 1'b0);
        tick("idle");

        // Toggle: A every 5 cycles, B every 10 cycles
        for (int k = 0; k < 40; k++) begin
            drive(1'((k / 5) % 2), 1'((k / 10) % 2), 1'b0);
            #1;
            check("tog_y", 32'(y1), 32'((k % 20) >= 15));
            tick("tog");
        end
        drive(1'b0, 1'b0, 1'b0);
        tick("tog_drain");
        drive(1'b0, 1'b0, 1'b0);
        tick("tog_drain");
        check("tog_cnt_total", 32'(cnt1), 32'd3);

        // Clear colliding with an event
        drive(1'b1, 1'b1, 1'b0);
        tick("col_rise");
        drive(1'b1, 1'b1, 1'b1);
        tick("col_clr");
        check("col_cnt", 32'(cnt1), 32'd0);
        check("col_all_kept", 32'(allq1), 32'd1);
        drive(1'b1, 1'b1, 1'b0);
        tick("col_hold");
        check("col_no_reevent", 32'(cnt1), 32'd0);

        // Fresh event, then reset mid-run with A = B = 1
        drive(1'b0, 1'b0, 1'b0);
        tick("pre_rst");
        drive(1'b1, 1'b1, 1'b0);
        tick("pre_rst");
        drive(1'b1, 1'b1, 1'b0);
        tick("pre_rst");
        check("pre_rst_cnt", 32'(cnt1), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_yq",  32'(yq1),   32'd0);
        check("mid_rst_all", 32'(allq1), 32'd0);
        check("mid_rst_cnt", 32'(cnt1),  32'd0);
        check("mid_rst_sat", 32'(sat1),  32'd0);
        check("mid_rst_y",   32'(y1),    32'd1);
        m_all_q = 1'b0; m_all_d = 1'b0; m_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        tick("rel1");
        check("rel1_cnt", 32'(cnt1), 32'd0);
        drive(1'b1, 1'b1, 1'b0);
        tick("rel2");
        check("rel2_cnt", 32'(cnt1), 32'd1);

        // Saturation on the 2-bit counter: five pulses
        for (int p = 0; p < 5; p++) begin
            a2 = 1'b1; b2 = 1'b1;
            drive(1'b0, 1'b0, 1'b0);
            tick("sat_bg");
            a2 = 1'b0; b2 = 1'b0;
            drive(1'b0, 1'b0, 1'b0);
            tick("sat_bg");
            drive(1'b0, 1'b0, 1'b0);
            tick("sat_bg");
            if (p == 1) begin
                check("sat_cnt_p2", 32'(cnt2), 32'd2);
                check("sat_flag_p2", 32'(sat2), 32'd0);
            end
        end
        check("sat_cnt", 32'(cnt2), 32'd3);
        check("sat_flag", 32'(sat2), 32'd1);
        clr2 = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        tick("sat_clr");
        clr2 = 1'b0;
        check("sat_clr_cnt", 32'(cnt2), 32'd0);
        check("sat_clr_flag", 32'(sat2), 32'd0);

        // Wide instance
        a4 = 4'hF; b4 = 4'hA;
        #1;
        check("w4_y", 32'(y4), 32'hA);
        drive(1'b0, 1'b0, 1'b0);
        tick("w4_bg");
        check("w4_yq", 32'(yq4), 32'hA);
        check("w4_all0", 32'(allq4), 32'd0);
        b4 = 4'hF;
        #1;
        check("w4_y_f", 32'(y4), 32'hF);
        drive(1'b0, 1'b0, 1'b0);
        tick("w4_bg");
        check("w4_all1", 32'(allq4), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
